// File: rtl/mem_reader_ctrl_param_if.sv
// ----------------------------------------------------------------------------
// mem_reader_ctrl_param_if
// Bundles the control, memory-read and buffer-write signals of the memory
// reader controller. Signal suffixes are from the controller's point of view:
// _i is driven by the environment, _o by the controller.
//   master : the controller (drives reads, strobes and status)
//   slave  : the environment (drives start, write_inp_en, bases, buf_ready)
// Signals:
//   start_i, write_inp_en_i        command pulses, sampled in IDLE
//   filter_base_i, img_base_i      region base addresses, captured in INIT
//   buf_ready_i                    downstream can accept; low stalls issue
//   mem_rd_en_o, mem_adr_o         memory read request and address
//   mem_offset_sel_o               0 = filter region, 1 = image region
//   filter_wr_en_o, filter_idx_o, filter_word_idx_o   filter buffer write
//   img_wr_en_o, img_word_idx_o    image buffer write
//   write_mem_en_o                 single memory write strobe
//   busy_o, done_o                 status
// ----------------------------------------------------------------------------
interface mem_reader_ctrl_param_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              start_i;
    logic              write_inp_en_i;
    logic [ADDR_W-1:0] filter_base_i;
    logic [ADDR_W-1:0] img_base_i;
    logic              buf_ready_i;
    logic              mem_rd_en_o;
    logic [ADDR_W-1:0] mem_adr_o;
    logic [1:0]        mem_offset_sel_o;
    logic              filter_wr_en_o;
    logic [7:0]        filter_idx_o;
    logic [7:0]        filter_word_idx_o;
    logic              img_wr_en_o;
    logic [15:0]       img_word_idx_o;
    logic              write_mem_en_o;
    logic              busy_o;
    logic              done_o;

    modport master (
        input  start_i, write_inp_en_i, filter_base_i, img_base_i, buf_ready_i,
        output mem_rd_en_o, mem_adr_o, mem_offset_sel_o,
               filter_wr_en_o, filter_idx_o, filter_word_idx_o,
               img_wr_en_o, img_word_idx_o, write_mem_en_o, busy_o, done_o
    );

    modport slave (
        output start_i, write_inp_en_i, filter_base_i, img_base_i, buf_ready_i,
        input  mem_rd_en_o, mem_adr_o, mem_offset_sel_o,
               filter_wr_en_o, filter_idx_o, filter_word_idx_o,
               img_wr_en_o, img_word_idx_o, write_mem_en_o, busy_o, done_o
    );
endinterface

// File: rtl/mem_reader_ctrl_param.sv
// ----------------------------------------------------------------------------
// mem_reader_ctrl_param
// Streams NUM_FILTERS x FILTER_WORDS filter words followed by the image words
// (IMG_SIZE*IMG_SIZE/PIX_PER_WORD) from data memory into the filter/image
// buffers, or performs a single input write. Reads are issued one per cycle
// while buf_ready is high; a MEM_LAT-deep return pipeline re-times the buffer
// write strobes and indices to the returning memory data.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-high reset
//   bus    mem_reader_ctrl_param_if.master (commands, reads, strobes, status)
// ----------------------------------------------------------------------------
module mem_reader_ctrl_param #(
    parameter int unsigned NUM_FILTERS  = 4,
    parameter int unsigned FILTER_WORDS = 4,
    parameter int unsigned IMG_SIZE     = 16,
    parameter int unsigned PIX_PER_WORD = 4,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned MEM_LAT      = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    mem_reader_ctrl_param_if.master      bus
);

    localparam int unsigned IMG_WORDS = IMG_SIZE * IMG_SIZE / PIX_PER_WORD;
    localparam logic [7:0]  K_LAST    = 8'(FILTER_WORDS - 1);
    localparam logic [7:0]  F_LAST    = 8'(NUM_FILTERS - 1);
    localparam logic [15:0] I_LAST    = 16'(IMG_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE, INIT, LD_FILTER, LD_IMG, DRAIN, WR_INP, DONE
    } state_e;

    // One return-pipeline slot: what the read issued MEM_LAT cycles earlier was.
    typedef struct packed {
        logic        v;
        logic        img;
        logic [7:0]  f;
        logic [7:0]  k;
        logic [15:0] i;
    } ret_t;

    state_e            state_q;
    logic [ADDR_W-1:0] adr_q;
    logic [ADDR_W-1:0] img_base_q;
    logic [7:0]        f_q;
    logic [7:0]        k_q;
    logic [15:0]       i_q;
    ret_t              pipe_q [MEM_LAT];

    logic issue;
    logic issue_img;
    logic pipe_busy;

    assign issue     = ((state_q == LD_FILTER) || (state_q == LD_IMG)) && bus.buf_ready_i;
    assign issue_img = (state_q == LD_IMG);

    // The last slot is presented on the outputs this cycle; DRAIN may leave as
    // soon as no earlier slot still holds a read, so DONE lines up with the
    // final strobe's cycle + 1.
    always_comb begin
        pipe_busy = 1'b0;
        for (int unsigned j = 0; j + 1 < MEM_LAT; j++) begin
            pipe_busy = pipe_busy | pipe_q[j].v;
        end
    end

    // Index fields only load with a valid read of their region, so the index
    // outputs hold their last value across bubbles and the other region.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned j = 0; j < MEM_LAT; j++) begin
                pipe_q[j] <= '0;
            end
        end else begin
            pipe_q[0].v   <= issue;
            pipe_q[0].img <= issue_img;
            if (issue && !issue_img) begin
                pipe_q[0].f <= f_q;
                pipe_q[0].k <= k_q;
            end
            if (issue && issue_img) begin
                pipe_q[0].i <= i_q;
            end
            for (int unsigned j = 1; j < MEM_LAT; j++) begin
                pipe_q[j].v   <= pipe_q[j-1].v;
                pipe_q[j].img <= pipe_q[j-1].img;
                if (pipe_q[j-1].v && !pipe_q[j-1].img) begin
                    pipe_q[j].f <= pipe_q[j-1].f;
                    pipe_q[j].k <= pipe_q[j-1].k;
                end
                if (pipe_q[j-1].v && pipe_q[j-1].img) begin
                    pipe_q[j].i <= pipe_q[j-1].i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            adr_q      <= '0;
            img_base_q <= '0;
            f_q        <= '0;
            k_q        <= '0;
            i_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.write_inp_en_i) begin
                        state_q <= WR_INP;
                    end else if (bus.start_i) begin
                        state_q <= INIT;
                    end
                end
                INIT: begin
                    adr_q      <= bus.filter_base_i;
                    img_base_q <= bus.img_base_i;
                    f_q        <= '0;
                    k_q        <= '0;
                    i_q        <= '0;
                    state_q    <= LD_FILTER;
                end
                LD_FILTER: begin
                    // Filter words are contiguous, so the address simply
                    // increments; it jumps to the image base after the last one.
                    if (bus.buf_ready_i) begin
                        adr_q <= adr_q + ADDR_W'(1);
                        if (k_q == K_LAST) begin
                            k_q <= '0;
                            if (f_q == F_LAST) begin
                                f_q     <= '0;
                                adr_q   <= img_base_q;
                                state_q <= LD_IMG;
                            end else begin
                                f_q <= f_q + 8'd1;
                            end
                        end else begin
                            k_q <= k_q + 8'd1;
                        end
                    end
                end
                LD_IMG: begin
                    if (bus.buf_ready_i) begin
                        adr_q <= adr_q + ADDR_W'(1);
                        i_q   <= i_q + 16'd1;
                        if (i_q == I_LAST) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!pipe_busy) begin
                        state_q <= DONE;
                    end
                end
                WR_INP:  state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_rd_en_o       = issue;
    assign bus.mem_adr_o         = adr_q;
    assign bus.mem_offset_sel_o  = {1'b0, issue_img};
    assign bus.filter_wr_en_o    = pipe_q[MEM_LAT-1].v && !pipe_q[MEM_LAT-1].img;
    assign bus.img_wr_en_o       = pipe_q[MEM_LAT-1].v && pipe_q[MEM_LAT-1].img;
    assign bus.filter_idx_o      = pipe_q[MEM_LAT-1].f;
    assign bus.filter_word_idx_o = pipe_q[MEM_LAT-1].k;
    assign bus.img_word_idx_o    = pipe_q[MEM_LAT-1].i;
    assign bus.write_mem_en_o    = (state_q == WR_INP);
    assign bus.busy_o            = (state_q != IDLE);
    assign bus.done_o            = (state_q == DONE);

endmodule

// File: tb/tb_mem_reader_ctrl_param.sv
module tb_mem_reader_ctrl_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_reader_ctrl_param_if #(.ADDR_W(16)) b0 ();
    mem_reader_ctrl_param_if #(.ADDR_W(16)) b1 ();

    mem_reader_ctrl_param #(
        .NUM_FILTERS(4), .FILTER_WORDS(4), .IMG_SIZE(16),
        .PIX_PER_WORD(4), .ADDR_W(16), .MEM_LAT(1)
    ) dut0 (.clk_i(clk), .rst_i(rst), .bus(b0));

    mem_reader_ctrl_param #(
        .NUM_FILTERS(2), .FILTER_WORDS(3), .IMG_SIZE(4),
        .PIX_PER_WORD(2), .ADDR_W(16), .MEM_LAT(3)
    ) dut1 (.clk_i(clk), .rst_i(rst), .bus(b1));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rd;
        logic [15:0] adr;
        logic [1:0]  sel;
        logic        fw;
        logic [7:0]  fi;
        logic [7:0]  fk;
        logic        iw;
        logic [15:0] ii;
        logic        wm;
        logic        busy;
        logic        done;
    } obs_t;

    // Expected buffer write: due cycle and which word it is.
    typedef struct {
        int cyc;
        bit img;
        int f;
        int k;
        int i;
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic obs_t sample(input int which);
        obs_t o;
        if (which == 0) begin
            o.rd = b0.mem_rd_en_o;    o.adr = b0.mem_adr_o;       o.sel = b0.mem_offset_sel_o;
            o.fw = b0.filter_wr_en_o; o.fi = b0.filter_idx_o;     o.fk = b0.filter_word_idx_o;
            o.iw = b0.img_wr_en_o;    o.ii = b0.img_word_idx_o;   o.wm = b0.write_mem_en_o;
            o.busy = b0.busy_o;       o.done = b0.done_o;
        end else begin
            o.rd = b1.mem_rd_en_o;    o.adr = b1.mem_adr_o;       o.sel = b1.mem_offset_sel_o;
            o.fw = b1.filter_wr_en_o; o.fi = b1.filter_idx_o;     o.fk = b1.filter_word_idx_o;
            o.iw = b1.img_wr_en_o;    o.ii = b1.img_word_idx_o;   o.wm = b1.write_mem_en_o;
            o.busy = b1.busy_o;       o.done = b1.done_o;
        end
        return o;
    endfunction

    task automatic set_in(input int which, input logic st, input logic wie, input logic br,
                          input logic [15:0] fb, input logic [15:0] ib);
        if (which == 0) begin
            b0.start_i = st; b0.write_inp_en_i = wie; b0.buf_ready_i = br;
            b0.filter_base_i = fb; b0.img_base_i = ib;
        end else begin
            b1.start_i = st; b1.write_inp_en_i = wie; b1.buf_ready_i = br;
            b1.filter_base_i = fb; b1.img_base_i = ib;
        end
    endtask

    task automatic chk_quiet(input int which, input string tag);
        obs_t o;
        o = sample(which);
        chk({tag, "_rd"}, o.rd, 1'b0);
        chk({tag, "_fw"}, o.fw, 1'b0);
        chk({tag, "_iw"}, o.iw, 1'b0);
        chk({tag, "_wm"}, o.wm, 1'b0);
        chk({tag, "_busy"}, o.busy, 1'b0);
        chk({tag, "_done"}, o.done, 1'b0);
        chk({tag, "_sel"}, o.sel, 2'd0);
    endtask

    // Full load run. Called just after a rising edge with the DUT idle.
    // Model: reads are numbered n = 0..N-1; read n targets fb+n (filter) or
    // ib+(n-NF) (image); one read per cycle from cycle 2 while buf_ready;
    // each read strobes its buffer L cycles later; done one cycle after the
    // last strobe. Bases are scrambled after capture to prove they were latched.
    task automatic run_load(input int which, input int L, input int nf, input int fw,
                            input int imgw, input logic [15:0] fb, input logic [15:0] ib,
                            input int stall_after, input int stall_len, input bit rand_stall,
                            input int abort_at);
        int   nfw;
        int   n_tot;
        int   n;
        int   c;
        int   done_cyc;
        int   stall_left;
        bit   br;
        bit   exp_rd;
        obs_t o;
        exp_t q[$];
        exp_t e;
        logic [15:0] ea;
        logic [15:0] fbd;
        logic [15:0] ibd;
        nfw = nf * fw;
        n_tot = nfw + imgw;
        n = 0;
        done_cyc = 1 << 30;
        stall_left = 0;
        fbd = fb;
        ibd = ib;
        set_in(which, 1'b1, 1'b0, 1'b1, fbd, ibd);
        @(posedge clk); #1;
        for (c = 1; c <= done_cyc + 1 && c < 3000; c++) begin
            if (rand_stall) br = ($urandom_range(0, 3) != 0);
            else if (stall_left > 0) begin br = 1'b0; stall_left--; end
            else br = 1'b1;
            if (c == 2) begin fbd = ~fb; ibd = ~ib; end
            // commands while busy must be ignored
            set_in(which, c == 5, c == 5, br, fbd, ibd);
            @(negedge clk);
            o = sample(which);
            exp_rd = (c >= 2) && (n < n_tot) && br;
            chk("rd_en", o.rd, exp_rd);
            if (exp_rd) begin
                ea = (n < nfw) ? fb + 16'(n) : ib + 16'(n - nfw);
                chk("adr", o.adr, ea);
                chk("sel", o.sel, (n < nfw) ? 2'd0 : 2'd1);
                e.cyc = c + L; e.img = (n >= nfw); e.f = n / fw; e.k = n % fw; e.i = n - nfw;
                q.push_back(e);
                n++;
                if (n == n_tot) done_cyc = c + L + 1;
                if (n == stall_after) stall_left = stall_len;
            end
            if (q.size() > 0 && q[0].cyc == c) begin
                e = q.pop_front();
                chk("filter_wr_en", o.fw, !e.img);
                chk("img_wr_en", o.iw, e.img);
                if (!e.img) begin
                    chk("filter_idx", o.fi, e.f);
                    chk("filter_word_idx", o.fk, e.k);
                end else begin
                    chk("img_word_idx", o.ii, e.i);
                end
            end else begin
                chk("filter_wr_en_idle", o.fw, 1'b0);
                chk("img_wr_en_idle", o.iw, 1'b0);
            end
            chk("busy", o.busy, c <= done_cyc);
            chk("done", o.done, c == done_cyc);
            chk("write_mem_en", o.wm, 1'b0);
            if (exp_rd && n == abort_at) begin
                #2 rst = 1'b1;
                #1 chk_quiet(which, "abort_now");
                @(posedge clk); #1;
                rst = 1'b0;
                set_in(which, 1'b0, 1'b0, 1'b1, fb, ib);
                for (int t = 0; t < 4; t++) begin
                    @(negedge clk);
                    chk_quiet(which, "abort_after");
                    @(posedge clk); #1;
                end
                return;
            end
            @(posedge clk); #1;
        end
        if (done_cyc == (1 << 30)) begin
            total++;
            bad++;
            $error("FAIL timeout observed_reads=%0d expected_reads=%0d", n, n_tot);
        end
        set_in(which, 1'b0, 1'b0, 1'b1, fb, ib);
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
        set_in(1, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk_quiet(0, "reset0");
        chk_quiet(1, "reset1");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // baseline load, default parameters
        run_load(0, 1, 4, 4, 64, 16'h0100, 16'h0200, 0, 0, 1'b0, -1);
        // small configuration with 3-cycle memory latency
        run_load(1, 3, 2, 3, 8, 16'h0100, 16'h0200, 0, 0, 1'b0, -1);
        // back-pressure for 5 cycles after the 10th read
        run_load(0, 1, 4, 4, 64, 16'h0100, 16'h0200, 10, 5, 1'b0, -1);

        // write has priority over start
        set_in(0, 1'b1, 1'b1, 1'b1, 16'h0100, 16'h0200);
        @(posedge clk); #1;
        set_in(0, 1'b0, 1'b0, 1'b1, 16'h0100, 16'h0200);
        @(negedge clk);
        chk("wr_wm", b0.write_mem_en_o, 1'b1);
        chk("wr_busy", b0.busy_o, 1'b1);
        chk("wr_rd", b0.mem_rd_en_o, 1'b0);
        chk("wr_done0", b0.done_o, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wr_done", b0.done_o, 1'b1);
        chk("wr_wm_off", b0.write_mem_en_o, 1'b0);
        chk("wr_rd2", b0.mem_rd_en_o, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk_quiet(0, "wr_idle");
        @(posedge clk); #1;

        // abort at the 30th read, then a clean restart from filter 0 word 0
        run_load(0, 1, 4, 4, 64, 16'h0100, 16'h0200, 0, 0, 1'b0, 30);
        run_load(0, 1, 4, 4, 64, 16'h0100, 16'h0200, 0, 0, 1'b0, -1);

        // image region wrapping past the top of the address space
        run_load(0, 1, 4, 4, 64, 16'h0100, 16'hFFFE, 0, 0, 1'b0, -1);

        // random bases and random back-pressure on both configurations
        for (int r = 0; r < 3; r++) begin
            run_load(0, 1, 4, 4, 64, 16'($urandom), 16'($urandom), 0, 0, 1'b1, -1);
            run_load(1, 3, 2, 3, 8, 16'($urandom), 16'($urandom), 0, 0, 1'b1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
